// File: rtl/button_conditioner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_if
//  Description : Button bundle between the raw push-buttons / conditioner and
//                the downstream operand/opcode latch stage. The master side
//                drives the raw buttons and consumes the conditioned pulses
//                and levels; the slave side is the conditioner itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
  parameter int NB_BUT = 3
);
  logic [NB_BUT-1:0] i_but;        // raw asynchronous buttons, active-high
  logic [NB_BUT-1:0] o_but_pulse;  // one-cycle load-enable per accepted press
  logic [NB_BUT-1:0] o_but_level;  // debounced button level

  modport master (
    output i_but,
    input  o_but_pulse,
    input  o_but_level
  );

  modport slave (
    input  i_but,
    output o_but_pulse,
    output o_but_level
  );
endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Per-button 2-FF synchroniser, debounce FSM and one-clock
//                load-enable pulse generator. Channels are fully independent.
//                Optional macro BTN_AUTOREPEAT_EN adds auto-repeat pulses
//                while a button stays held.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int NB_BUT          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst_n,
  button_conditioner_if.slave btn_bus
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  // The repeat counter reloads to DELAY-PERIOD so that every later pulse is
  // exactly REPEAT_PERIOD cycles after the previous one.
  localparam int RPT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RPT_W-1:0] C_RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] C_RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  // Reject parameter sets the counters cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
    $error("button_conditioner: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  wire [NB_BUT-1:0] w_pulse;
  wire [NB_BUT-1:0] w_level;

  for (genvar gi = 0; gi < NB_BUT; gi++) begin : g_ch
    logic [1:0]       r_sync;
    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_level;
`ifdef BTN_AUTOREPEAT_EN
    logic [RPT_W-1:0] r_rpt;
`endif

    // Two-flop synchroniser; only its second stage is seen by the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sync <= 2'b00;
      end else begin
        r_sync <= {r_sync[0], btn_bus.i_but[gi]};
      end
    end

    assign w_s = r_sync[1];

    // Debounce FSM with registered pulse/level outputs and optional auto-repeat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_level <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_rpt   <= '0;
`endif
      end else begin
        r_pulse <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_s) begin
              r_state <= ST_DB_PRESS;
              r_cnt   <= '0;
            end
          end
          ST_DB_PRESS: begin
            if (!w_s) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == C_CNT_LAST) begin
              r_state <= ST_HELD;
              r_pulse <= 1'b1;
              r_level <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              r_rpt   <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!w_s) begin
              r_state <= ST_DB_RELEASE;
              r_cnt   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (r_rpt == C_RPT_LAST) begin
              r_pulse <= 1'b1;
              r_rpt   <= C_RPT_RELOAD;
            end else begin
              r_rpt <= r_rpt + RPT_W'(1);
            end
`endif
          end
          ST_DB_RELEASE: begin
            // Repeat counter is left frozen here and cleared on return to HELD.
            if (w_s) begin
              r_state <= ST_HELD;
`ifdef BTN_AUTOREPEAT_EN
              r_rpt   <= '0;
`endif
            end else if (r_cnt == C_CNT_LAST) begin
              r_state <= ST_IDLE;
              r_level <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end

    assign w_pulse[gi] = r_pulse;
    assign w_level[gi] = r_level;
  end : g_ch

  assign btn_bus.o_but_pulse = w_pulse;
  assign btn_bus.o_but_level = w_level;

endmodule : button_conditioner
`default_nettype wire
